// File: rtl/uart_tx_fifo_drain_if.sv
// uart_tx_fifo_drain_if
//   Bundles the UART transmitter's baud tick, fifo read handshake and serial
//   outputs into one interface. Signal names keep the i_/o_ prefixes of the
//   transmitter's own port list, so i_* are inputs to the UART and o_* are its
//   outputs.
//
//   Fifo read handshake: the UART raises o_fifo_read for exactly one cycle
//   while i_fifo_empty is low. The fifo samples that pulse on the next rising
//   edge and presents the popped word on i_fifo_data from that edge onwards.
//   Only one read is ever outstanding.
//
//   Modports
//     master : upstream side (fifo + baud generator) - drives i_*, observes o_*
//     slave  : the transmitter - observes i_*, drives o_* and dbg_state
//
//   Signals
//     i_tick        baud tick, 1-cycle pulse, OVERSAMPLE per bit time
//     i_fifo_empty  fifo empty flag
//     i_fifo_data   fifo read data (registered in the fifo)
//     o_fifo_read   1-cycle pop request
//     o_tx          serial line, idle high
//     o_busy        high while a frame is being fetched or sent
//     o_tx_done     1-cycle pulse on the last stop tick
//     dbg_state     encoded FSM state of the transmitter
interface uart_tx_fifo_drain_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_tick;
  logic                  i_fifo_empty;
  logic [DATA_WIDTH-1:0] i_fifo_data;
  logic                  o_fifo_read;
  logic                  o_tx;
  logic                  o_busy;
  logic                  o_tx_done;
  logic [2:0]            dbg_state;

  modport master (
    output i_tick, i_fifo_empty, i_fifo_data,
    input  o_fifo_read, o_tx, o_busy, o_tx_done, dbg_state
  );

  modport slave (
    input  i_tick, i_fifo_empty, i_fifo_data,
    output o_fifo_read, o_tx, o_busy, o_tx_done, dbg_state
  );
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain
//   UART transmitter placed directly after the TX fifo. Pops one word per
//   frame through the fifo read handshake and sends it as
//   start + LSB-first data (+ optional parity) + stop on o_tx.
//
//   Optional feature macro: UART_TX_PARITY_EN
//     defined   - a parity bit (^data ^ PARITY_ODD) follows the data bits
//     undefined - data is followed directly by the stop bit
//
//   Ports
//     i_clock  system clock, everything on the rising edge
//     i_reset  synchronous, active-high reset
//     bus      uart_tx_fifo_drain_if.slave (tick, fifo handshake, serial out,
//              busy, done, dbg_state)
//
//   Parameters
//     DATA_WIDTH  data bits per frame (must match the fifo width)
//     OVERSAMPLE  ticks per start/data/parity bit
//     SB_TICK     ticks for the stop period (16 = 1 stop bit, 32 = 2)
//     PARITY_ODD  0 = even parity, 1 = odd parity (parity build only)
module uart_tx_fifo_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16,
  parameter int PARITY_ODD = 0
) (
  input logic                  i_clock,
  input logic                  i_reset,
  uart_tx_fifo_drain_if.slave  bus
);

  localparam int TICK_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int TW       = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam int BW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  // Only 0 and 1 are meaningful parity senses; the empty block below simply
  // names an out-of-range setting in the elaborated hierarchy.
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_parity_odd_out_of_range
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd5,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t                state;
  logic [TW-1:0]         tick_cnt;
  logic [BW-1:0]         bit_cnt;
  logic                  fetch_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic                  tx_q;
  logic                  read_q;
  logic                  busy_q;
  logic                  done_q;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q;
`endif

  // Word after the current bit has been shifted out; its LSB is the next bit.
  always_comb begin
    shift_next = shift_reg >> 1;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      fetch_cnt <= 1'b0;
      shift_reg <= '0;
      tx_q      <= 1'b1;
      read_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      read_q <= 1'b0;
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (!bus.i_fifo_empty) begin
            read_q    <= 1'b1;
            busy_q    <= 1'b1;
            fetch_cnt <= 1'b0;
            state     <= S_FETCH;
          end
        end

        // First edge: the fifo samples the pop. Second edge: its registered
        // output now holds the word, so latch it. Ticks are ignored here.
        S_FETCH: begin
          if (!fetch_cnt) begin
            fetch_cnt <= 1'b1;
          end else begin
            fetch_cnt <= 1'b0;
            shift_reg <= bus.i_fifo_data;
`ifdef UART_TX_PARITY_EN
            parity_q  <= (^bus.i_fifo_data) ^ (PARITY_ODD != 0);
`endif
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            tx_q      <= 1'b0;
            state     <= S_START;
          end
        end

        S_START: begin
          if (bus.i_tick) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt <= '0;
              tx_q     <= shift_reg[0];
              state    <= S_DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        S_DATA: begin
          if (bus.i_tick) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt  <= '0;
              shift_reg <= shift_next;
              if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                tx_q    <= parity_q;
                state   <= S_PARITY;
`else
                tx_q    <= 1'b1;
                state   <= S_STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                tx_q    <= shift_next[0];
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bus.i_tick) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt <= '0;
              tx_q     <= 1'b1;
              state    <= S_STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`endif

        S_STOP: begin
          if (bus.i_tick) begin
            if (tick_cnt == SB_LAST) begin
              tick_cnt <= '0;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state    <= S_IDLE;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        default: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_tx        = tx_q;
  assign bus.o_fifo_read = read_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_tx_done   = done_q;
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb_uart_tx_fifo_drain
//   Directed bench for uart_tx_fifo_drain: a small fifo model with a
//   registered read port feeds the transmitter, o_tx / o_fifo_read /
//   o_tx_done are logged once per cycle on the falling edge, and each test
//   task decodes the log against hand-computed frames.
//   Optional feature macro: UART_TX_PARITY_EN (adds the parity slot).
module tb_uart_tx_fifo_drain;

  localparam int LOG_N = 2000;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_fifo_drain_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_fifo_drain #(
    .DATA_WIDTH(8), .OVERSAMPLE(16), .SB_TICK(16), .PARITY_ODD(0)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;

  // ---------------- baud tick generator ----------------
  int tick_div   = 1;
  int tick_phase = 0;
  initial bus.i_tick = 1'b1;
  always @(negedge clk) begin
    if (tick_phase >= tick_div - 1) tick_phase = 0;
    else tick_phase = tick_phase + 1;
    bus.i_tick = (tick_phase == 0);
  end

  // ---------------- fifo model (registered output) ----------------
  logic [7:0] mem [0:15];
  logic [3:0] wr_ptr = '0;
  logic [3:0] rd_ptr = '0;
  assign bus.i_fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (bus.o_fifo_read && (wr_ptr != rd_ptr)) begin
      bus.i_fifo_data <= mem[rd_ptr];
      rd_ptr          <= rd_ptr + 4'd1;
    end
  end

  task automatic push(input logic [7:0] v);
    mem[wr_ptr] = v;
    wr_ptr      = wr_ptr + 4'd1;
  endtask

  // ---------------- per-cycle log ----------------
  logic tx_log [0:LOG_N-1];
  logic rd_log [0:LOG_N-1];
  logic dn_log [0:LOG_N-1];
  int   rec_len = 0;

  task automatic record(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tx_log[i] = bus.o_tx;
      rd_log[i] = bus.o_fifo_read;
      dn_log[i] = bus.o_tx_done;
    end
    rec_len = n;
  endtask

  // kind 0: read pulse, 1: done pulse, 2: tx low, 3: tx high
  function automatic logic log_bit(input int kind, input int idx);
    if (idx < 0 || idx >= rec_len) return 1'b0;
    case (kind)
      0: return rd_log[idx];
      1: return dn_log[idx];
      2: return !tx_log[idx];
      default: return tx_log[idx];
    endcase
  endfunction

  function automatic int find_from(input int kind, input int from);
    for (int i = (from < 0 ? 0 : from); i < rec_len; i++)
      if (log_bit(kind, i)) return i;
    return -1;
  endfunction

  function automatic int count_set(input int kind);
    int c = 0;
    for (int i = 0; i < rec_len; i++) if (log_bit(kind, i)) c++;
    return c;
  endfunction

  function automatic int run_len(input int kind, input int from);
    int c = 0;
    while (log_bit(kind, from + c)) c++;
    return c;
  endfunction

  // Mid-bit sample of slot k (0 = start, 1..8 = data, then parity/stop).
  function automatic logic slot_bit(input int s, input int bc, input int k);
    int idx = s + bc / 2 + k * bc;
    if (idx < 0 || idx >= rec_len) return 1'bx;
    return tx_log[idx];
  endfunction

  function automatic logic [7:0] decode(input int s, input int bc);
    logic [7:0] v = '0;
    for (int k = 0; k < 8; k++) v[k] = slot_bit(s, bc, k + 1);
    return v;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] got;
    int r;
    push(8'h96);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++;
      if ({bus.o_tx, bus.o_fifo_read, bus.o_busy} !== 3'b100) begin
        fails++;
        $display("FAIL reset_hold cycle %0d: tx/read/busy=%b expected 100", c,
                 {bus.o_tx, bus.o_fifo_read, bus.o_busy});
      end
    end
    rst = 1'b0;
    record(300);
    r = find_from(0, 0);
    got = decode(r + 2, 16);
    tests++;
    if (got !== 8'h96) begin
      fails++;
      $display("FAIL reset_then_send: got %h expected 96", got);
    end
  endtask

  task automatic test_empty();
    int n;
    record(200);
    n = count_set(0);
    tests++;
    if (n !== 0) begin
      fails++;
      $display("FAIL empty_no_read: reads %0d expected 0", n);
    end
    n = count_set(2);
    tests++;
    if (n !== 0) begin
      fails++;
      $display("FAIL empty_tx_idle: low cycles %0d expected 0", n);
    end
  endtask

  task automatic test_single();
    int r, d, n;
    logic [7:0] got;
    push(8'hA5);
    record(300);
    r = find_from(0, 0);
    n = count_set(0);
    tests++;
    if (n !== 1) begin
      fails++;
      $display("FAIL single_reads: got %0d expected 1", n);
    end
    n = run_len(2, r + 2);
    tests++;
    if (n !== 16) begin
      fails++;
      $display("FAIL single_start_len: got %0d expected 16", n);
    end
    got = decode(r + 2, 16);
    tests++;
    if (got !== 8'hA5) begin
      fails++;
      $display("FAIL single_data: got %h expected a5", got);
    end
    tests++;
    if (slot_bit(r + 2, 16, 9 + PAR) !== 1'b1) begin
      fails++;
      $display("FAIL single_stop: got %b expected 1", slot_bit(r + 2, 16, 9 + PAR));
    end
    n = count_set(1);
    tests++;
    if (n !== 1) begin
      fails++;
      $display("FAIL single_done_count: got %0d expected 1", n);
    end
    d = find_from(1, r);
    // 2 fetch + 16 start + 128 data (+16 parity) + 16 stop cycles after the read
    tests++;
    if (d - r !== 162 + 16 * PAR) begin
      fails++;
      $display("FAIL single_done_delay: got %0d expected %0d", d - r, 162 + 16 * PAR);
    end
  endtask

  task automatic test_back_to_back();
    int r1, r2, d1, n;
    logic [7:0] got;
    push(8'h00);
    push(8'hFF);
    record(420);
    n = count_set(0);
    tests++;
    if (n !== 2) begin
      fails++;
      $display("FAIL b2b_reads: got %0d expected 2", n);
    end
    r1 = find_from(0, 0);
    d1 = find_from(1, r1);
    r2 = find_from(0, r1 + 1);
    tests++;
    if (!(d1 >= 0 && r2 > d1)) begin
      fails++;
      $display("FAIL b2b_gap: second read %0d first done %0d, required read after done", r2, d1);
    end
    tests++;
    if (r2 - r1 !== 163 + 16 * PAR) begin
      fails++;
      $display("FAIL b2b_period: got %0d expected %0d", r2 - r1, 163 + 16 * PAR);
    end
    got = decode(r1 + 2, 16);
    tests++;
    if (got !== 8'h00) begin
      fails++;
      $display("FAIL b2b_data0: got %h expected 00", got);
    end
    got = decode(r2 + 2, 16);
    tests++;
    if (got !== 8'hFF) begin
      fails++;
      $display("FAIL b2b_data1: got %h expected ff", got);
    end
    n = count_set(1);
    tests++;
    if (n !== 2) begin
      fails++;
      $display("FAIL b2b_done_count: got %0d expected 2", n);
    end
  endtask

  task automatic test_slow_tick();
    int r, s, h, n;
    logic [7:0] got;
    tick_div = 4;
    push(8'h3C);
    record(1000);
    r = find_from(0, 0);
    s = find_from(2, r);
    got = decode(s, 64);
    tests++;
    if (got !== 8'h3C) begin
      fails++;
      $display("FAIL slow_data: got %h expected 3c", got);
    end
    // 0x3C LSB-first is 0,0,1,1,1,1,0,0: four high bits = 256 cycles
    h = find_from(3, s);
    n = run_len(3, h);
    tests++;
    if (n !== 256) begin
      fails++;
      $display("FAIL slow_bit_len: high run %0d expected 256", n);
    end
    tests++;
    if (slot_bit(s, 64, 9 + PAR) !== 1'b1) begin
      fails++;
      $display("FAIL slow_stop: got %b expected 1", slot_bit(s, 64, 9 + PAR));
    end
    n = count_set(1);
    tests++;
    if (n !== 1) begin
      fails++;
      $display("FAIL slow_done_count: got %0d expected 1", n);
    end
    tick_div = 1;
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    int r, n;
    logic [7:0] got;
    push(8'h5A);
    push(8'hC3);
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.o_fifo_read) seen = 1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL midrst_read_timeout: no read within 50 cycles");
    end
    // read seen at cycle n; bit 3 occupies cycles n+66..n+81
    repeat (70) @(negedge clk);
    tests++;
    if (bus.dbg_state !== 3'd3) begin
      fails++;
      $display("FAIL midrst_in_data: state %0d expected 3", bus.dbg_state);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({bus.o_tx, bus.o_busy, bus.dbg_state} !== 5'b10000) begin
      fails++;
      $display("FAIL midrst_after: tx/busy/state=%b expected 10000",
               {bus.o_tx, bus.o_busy, bus.dbg_state});
    end
    rst = 1'b0;
    record(300);
    n = count_set(0);
    tests++;
    if (n !== 1) begin
      fails++;
      $display("FAIL midrst_reads: got %0d expected 1", n);
    end
    r = find_from(0, 0);
    got = decode(r + 2, 16);
    tests++;
    if (got !== 8'hC3) begin
      fails++;
      $display("FAIL midrst_next_word: got %h expected c3", got);
    end
    tests++;
    if (wr_ptr !== rd_ptr) begin
      fails++;
      $display("FAIL midrst_fifo_drained: rd_ptr %0d expected %0d", rd_ptr, wr_ptr);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int r;
    push(8'h07);
    record(300);
    r = find_from(0, 0);
    // three ones, even parity -> parity bit 1
    tests++;
    if (slot_bit(r + 2, 16, 9) !== 1'b1) begin
      fails++;
      $display("FAIL parity_even_07: got %b expected 1", slot_bit(r + 2, 16, 9));
    end
    tests++;
    if (decode(r + 2, 16) !== 8'h07) begin
      fails++;
      $display("FAIL parity_data: got %h expected 07", decode(r + 2, 16));
    end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_empty();
    test_single();
    test_back_to_back();
    test_slow_tick();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
